// File: rtl/rs_encode_line_pack_pkg.sv
// Shared types and constants for the RS encoder line-out datapath.
// The PARITY_W value here must agree with the parity width used by the encoder core.
package rs_encode_pkg;

    localparam int RS_WORD_W = 8;
    localparam int PARITY_W  = 256;

    typedef enum logic [1:0] {
        LP_IDLE   = 2'd0,
        LP_DATA   = 2'd1,
        LP_PARITY = 2'd2,
        LP_DRAIN  = 2'd3
    } rs_line_pack_state_e;

endpackage

// File: rtl/rs_encode_line_pack_if.sv
// Handshake bundle between the symbol source, the line packer and its two consumers.
// The slave modport is the packer's view; the master modport is the producer/consumer side.
interface rs_encode_line_pack_if
    import rs_encode_pkg::*;
#(
    parameter int DATA_W        = 256,
    parameter int SYMS_PER_BEAT = 4,
    parameter int MAX_MSG_BYTES = 4096
);
    localparam int MSG_W  = $clog2(MAX_MSG_BYTES + 1);
    localparam int LB_W   = $clog2(DATA_W / 8 + 1);
    localparam int BEAT_W = SYMS_PER_BEAT * RS_WORD_W;

    logic                start_val;
    logic [MSG_W-1:0]    start_msg_bytes;
    logic                start_rdy;
    logic                sym_val;
    logic [BEAT_W-1:0]   sym_data;
    logic                sym_rdy;
    logic                line_val;
    logic [DATA_W-1:0]   line_data;
    logic [LB_W-1:0]     line_bytes;
    logic                line_last;
    logic                line_rdy;
    logic                parity_val;
    logic [PARITY_W-1:0] parity_data;
    logic                parity_rdy;
    logic                err;

    modport master (
        output start_val, start_msg_bytes, sym_val, sym_data, line_rdy, parity_rdy,
        input  start_rdy, sym_rdy, line_val, line_data, line_bytes, line_last,
               parity_val, parity_data, err
    );

    modport slave (
        input  start_val, start_msg_bytes, sym_val, sym_data, line_rdy, parity_rdy,
        output start_rdy, sym_rdy, line_val, line_data, line_bytes, line_last,
               parity_val, parity_data, err
    );

endinterface

// File: rtl/rs_encode_line_pack_ctrl.sv
// Sequencing for the line packer: codeword FSM, byte counters and the strobes
// that steer the accumulator, line output and parity registers in the datapath.
module rs_encode_line_pack_ctrl
    import rs_encode_pkg::*;
#(
    parameter  int DATA_BYTES    = 32,
    parameter  int SYMS_PER_BEAT = 4,
    parameter  int PARITY_BYTES  = 32,
    parameter  int MAX_MSG_BYTES = 4096,
    localparam int MSG_W         = $clog2(MAX_MSG_BYTES + 1),
    localparam int OFF_W         = $clog2(DATA_BYTES + 1),
    localparam int POFF_W        = $clog2(PARITY_BYTES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_val,
    input  logic [MSG_W-1:0]  start_msg_bytes,
    input  logic              sym_val,
    input  logic              line_rdy,
    input  logic              parity_rdy,
    output logic              start_rdy,
    output logic              sym_rdy,
    output logic              err,
    output logic              line_val,
    output logic              parity_val,
    output logic              acc_clear,
    output logic              acc_wr,
    output logic              line_load,
    output logic              par_wr,
    output logic [OFF_W-1:0]  offset,
    output logic [POFF_W-1:0] par_off,
    output logic [OFF_W-1:0]  line_bytes_nxt,
    output logic              line_last_nxt
);
    // state    | meaning
    // IDLE     | waiting for a legal start request
    // DATA     | packing message symbols into lines
    // PARITY   | collecting parity symbols
    // DRAIN    | waiting for pending line/parity handshakes
    localparam logic [1:0] S_IDLE   = LP_IDLE;
    localparam logic [1:0] S_DATA   = LP_DATA;
    localparam logic [1:0] S_PARITY = LP_PARITY;
    localparam logic [1:0] S_DRAIN  = LP_DRAIN;

    localparam logic [OFF_W-1:0]  SPB_O = OFF_W'(SYMS_PER_BEAT);
    localparam logic [OFF_W-1:0]  DB_O  = OFF_W'(DATA_BYTES);
    localparam logic [MSG_W-1:0]  SPB_R = MSG_W'(SYMS_PER_BEAT);
    localparam logic [MSG_W-1:0]  MAX_R = MSG_W'(MAX_MSG_BYTES);
    localparam logic [POFF_W-1:0] SPB_P = POFF_W'(SYMS_PER_BEAT);
    localparam logic [POFF_W-1:0] PB_P  = POFF_W'(PARITY_BYTES);

    logic [1:0]       state, state_n;
    logic [MSG_W-1:0] remaining;
    logic             beat_done, par_done, legal, start_ok, beat;
    logic             line_val_n, parity_val_n;

    always_comb begin
        legal          = (start_msg_bytes != '0) && (start_msg_bytes <= MAX_R) &&
                         ((start_msg_bytes % SPB_R) == '0);
        start_rdy      = (state == S_IDLE);
        start_ok       = start_val && start_rdy && legal;
        acc_clear      = start_ok;
        beat_done      = ((offset + SPB_O) == DB_O) || (remaining == SPB_R);
        par_done       = ((par_off + SPB_P) == PB_P);
        line_bytes_nxt = offset + SPB_O;
        line_last_nxt  = (remaining == SPB_R);

        sym_rdy = 1'b0;
        case (state)
            S_DATA:   sym_rdy = !(beat_done && line_val && !line_rdy);
            S_PARITY: sym_rdy = !parity_val;
            default:  sym_rdy = 1'b0;
        endcase

        beat      = sym_val && sym_rdy;
        acc_wr    = beat && (state == S_DATA);
        line_load = acc_wr && beat_done;
        par_wr    = beat && (state == S_PARITY);

        // A load in the same cycle as a consumer handshake keeps line_val high.
        line_val_n   = line_load ? 1'b1 : (line_rdy ? 1'b0 : line_val);
        parity_val_n = (par_wr && par_done) ? 1'b1 : (parity_rdy ? 1'b0 : parity_val);

        state_n = state;
        case (state)
            S_IDLE:   if (start_ok) state_n = S_DATA;
            S_DATA:   if (line_load && line_last_nxt) state_n = S_PARITY;
            S_PARITY: if (par_wr && par_done) state_n = S_DRAIN;
            S_DRAIN:  if (!line_val_n && !parity_val_n) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            remaining  <= '0;
            offset     <= '0;
            par_off    <= '0;
            line_val   <= 1'b0;
            parity_val <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            line_val   <= line_val_n;
            parity_val <= parity_val_n;
            err        <= start_val && start_rdy && !legal;
            if (start_ok) begin
                remaining <= start_msg_bytes;
                offset    <= '0;
                par_off   <= '0;
            end
            if (acc_wr) begin
                remaining <= remaining - SPB_R;
                offset    <= beat_done ? '0 : offset + SPB_O;
            end
            if (par_wr) par_off <= par_off + SPB_P;
        end
    end

endmodule

// File: rtl/rs_encode_line_pack.sv
// Packs an RS codeword stream into DATA_W-bit data lines plus one parity block.
// Holds the accumulator, output line and parity registers; sequencing lives in the ctrl block.
module rs_encode_line_pack
    import rs_encode_pkg::*;
#(
    parameter int DATA_W        = 256,
    parameter int SYMS_PER_BEAT = 4,
    parameter int MAX_MSG_BYTES = 4096
) (
    input logic                  clk,
    input logic                  rst,
    rs_encode_line_pack_if.slave bus
);
    localparam int DATA_BYTES   = DATA_W / 8;
    localparam int PARITY_BYTES = PARITY_W / 8;
    localparam int BEAT_W       = SYMS_PER_BEAT * RS_WORD_W;
    localparam int OFF_W        = $clog2(DATA_BYTES + 1);
    localparam int POFF_W       = $clog2(PARITY_BYTES + 1);

    logic                acc_clear, acc_wr, line_load, par_wr, line_last_nxt;
    logic [OFF_W-1:0]    offset, line_bytes_nxt;
    logic [POFF_W-1:0]   par_off;
    logic [DATA_W-1:0]   acc, acc_merged, line_q;
    logic [OFF_W-1:0]    line_bytes_q;
    logic                line_last_q;
    logic [PARITY_W-1:0] par_q, par_merged;

    rs_encode_line_pack_ctrl #(
        .DATA_BYTES    (DATA_BYTES),
        .SYMS_PER_BEAT (SYMS_PER_BEAT),
        .PARITY_BYTES  (PARITY_BYTES),
        .MAX_MSG_BYTES (MAX_MSG_BYTES)
    ) u_ctrl (
        .clk             (clk),
        .rst             (rst),
        .start_val       (bus.start_val),
        .start_msg_bytes (bus.start_msg_bytes),
        .sym_val         (bus.sym_val),
        .line_rdy        (bus.line_rdy),
        .parity_rdy      (bus.parity_rdy),
        .start_rdy       (bus.start_rdy),
        .sym_rdy         (bus.sym_rdy),
        .err             (bus.err),
        .line_val        (bus.line_val),
        .parity_val      (bus.parity_val),
        .acc_clear       (acc_clear),
        .acc_wr          (acc_wr),
        .line_load       (line_load),
        .par_wr          (par_wr),
        .offset          (offset),
        .par_off         (par_off),
        .line_bytes_nxt  (line_bytes_nxt),
        .line_last_nxt   (line_last_nxt)
    );

    // Unwritten bytes are always zero, so a beat is merged by OR at its byte offset.
    always_comb begin
        acc_merged = acc | ({bus.sym_data, {(DATA_W - BEAT_W){1'b0}}} >> {offset, 3'b000});
        par_merged = par_q | ({bus.sym_data, {(PARITY_W - BEAT_W){1'b0}}} >> {par_off, 3'b000});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc          <= '0;
            line_q       <= '0;
            line_bytes_q <= '0;
            line_last_q  <= 1'b0;
            par_q        <= '0;
        end else begin
            if (acc_clear || line_load) acc <= '0;
            else if (acc_wr)            acc <= acc_merged;
            if (line_load) begin
                line_q       <= acc_merged;
                line_bytes_q <= line_bytes_nxt;
                line_last_q  <= line_last_nxt;
            end
            if (acc_clear)   par_q <= '0;
            else if (par_wr) par_q <= par_merged;
        end
    end

    assign bus.line_data   = line_q;
    assign bus.line_bytes  = line_bytes_q;
    assign bus.line_last   = line_last_q;
    assign bus.parity_data = par_q;

endmodule
